// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic note-event scheduler driving a bank of ADSR gates.
// One event in flight: IDLE -> DECIDE -> {KILL ->} ASSIGN -> IDLE.
// Build option: define VOICE_STEAL_EN to let note-ons steal releasing/gated
// voices (LRU); otherwise a note-on with no retrigger/free voice is dropped.
// Timing (edges after the handshake edge): DECIDE resolves at +1 (pulses,
// note-off gate fall), gate rises at +2 (direct) or +3 (via one-cycle KILL).

// Per-voice slot: gate, held note and LRU age for one envelope.
module voice_lane #(
  parameter int NOTE_W = 7,
  parameter int AW     = 2,
  parameter int LANE   = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sel,
  input  logic              clr_gate,
  input  logic              set_gate,
  input  logic              bump,
  input  logic [NOTE_W-1:0] note_in,
  input  logic [AW-1:0]     tgt_age,
  output logic              gate,
  output logic [NOTE_W-1:0] note,
  output logic [AW-1:0]     age
);
  // Gate/note updates apply to the selected lane; LRU aging applies to all lanes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gate <= 1'b0;
      note <= '0;
      age  <= AW'(LANE);
    end else begin
      if (sel && clr_gate) gate <= 1'b0;
      if (sel && set_gate) begin
        gate <= 1'b1;
        note <= note_in;
      end
      if (bump) begin
        if (sel)                 age <= '0;
        else if (age < tgt_age)  age <= age + 1'b1;
      end
    end
  end
endmodule

module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 7
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic                         note_on_i,
  input  logic [NOTE_W-1:0]            note_i,
  input  logic [NUM_VOICES-1:0]        env_busy_i,
  output logic [NUM_VOICES-1:0]        gate_o,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note_o,
  output logic                         drop_o,
  output logic                         steal_o
);
  localparam int VW = $clog2(NUM_VOICES);

  typedef enum logic [1:0] {IDLE, DECIDE, KILL, ASSIGN} state_t;

  state_t                             state, state_nxt;
  logic                               ev_on;
  logic [NOTE_W-1:0]                  ev_note;
  logic [VW-1:0]                      tgt;
  logic [NUM_VOICES-1:0]              gate;
  logic [NUM_VOICES-1:0][NOTE_W-1:0]  vnote;
  logic [NUM_VOICES-1:0][VW-1:0]      age;
  logic [NUM_VOICES-1:0]              sel;

  logic          hit_any, free_any, pick_ok, pick_steal;
  logic [VW-1:0] hit_idx, free_idx, pick;

  assign ready_o      = (state == IDLE);
  assign gate_o       = gate;
  assign voice_note_o = vnote;

  // Lowest-index gated note match and lowest-index fully idle voice.
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (gate[v] && vnote[v] == ev_note) begin
        hit_any = 1'b1;
        hit_idx = VW'(v);
      end
      if (!gate[v] && !env_busy_i[v]) begin
        free_any = 1'b1;
        free_idx = VW'(v);
      end
    end
  end

`ifdef VOICE_STEAL_EN
  logic          rel_any;
  logic [VW-1:0] rel_idx, rel_age, old_idx;

  // Steal candidates: oldest releasing voice, else the globally oldest voice.
  always_comb begin
    rel_any = 1'b0;
    rel_idx = '0;
    rel_age = '0;
    old_idx = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!gate[v] && (!rel_any || age[v] > rel_age)) begin
        rel_any = 1'b1;
        rel_idx = VW'(v);
        rel_age = age[v];
      end
      if (age[v] == VW'(NUM_VOICES - 1)) old_idx = VW'(v);
    end
  end

  // Note-on target priority: retrigger, free, releasing (steal), oldest (steal).
  always_comb begin
    pick       = '0;
    pick_ok    = 1'b1;
    pick_steal = 1'b0;
    if (hit_any)       pick = hit_idx;
    else if (free_any) pick = free_idx;
    else if (rel_any) begin
      pick       = rel_idx;
      pick_steal = 1'b1;
    end else begin
      pick       = old_idx;
      pick_steal = 1'b1;
    end
  end

  // Steal pulse registered as DECIDE resolves.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) steal_o <= 1'b0;
    else       steal_o <= (state == DECIDE) && ev_on && pick_steal;
  end
`else
  // Note-on target priority without stealing: retrigger, else free, else drop.
  always_comb begin
    pick       = '0;
    pick_ok    = 1'b0;
    pick_steal = 1'b0;
    if (hit_any) begin
      pick    = hit_idx;
      pick_ok = 1'b1;
    end else if (free_any) begin
      pick    = free_idx;
      pick_ok = 1'b1;
    end
  end

  assign steal_o = pick_steal;
`endif

  // Event latch, registered target and drop pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ev_on   <= 1'b0;
      ev_note <= '0;
      tgt     <= '0;
      drop_o  <= 1'b0;
    end else begin
      drop_o <= (state == DECIDE) && ev_on && !pick_ok;
      if (state == IDLE && valid_i) begin
        ev_on   <= note_on_i;
        ev_note <= note_i;
      end
      if (state == DECIDE) tgt <= pick;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state: a gated target goes through one KILL cycle first.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_i) state_nxt = DECIDE;
      DECIDE: begin
        if (!ev_on || !pick_ok) state_nxt = IDLE;
        else if (gate[pick])    state_nxt = KILL;
        else                    state_nxt = ASSIGN;
      end
      KILL:    state_nxt = ASSIGN;
      ASSIGN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane select: note-off acts on the match in DECIDE, later states on tgt.
  always_comb begin
    sel = '0;
    for (int v = 0; v < NUM_VOICES; v++)
      sel[v] = (state == DECIDE) ? (hit_idx == VW'(v)) : (tgt == VW'(v));
  end

  logic clr_gate, set_gate;
  assign clr_gate = (state == DECIDE && !ev_on && hit_any) || (state == KILL);
  assign set_gate = (state == ASSIGN);

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_lane
    voice_lane #(.NOTE_W(NOTE_W), .AW(VW), .LANE(v)) u_lane (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .sel      (sel[v]),
      .clr_gate (clr_gate),
      .set_gate (set_gate),
      .bump     (set_gate),
      .note_in  (ev_note),
      .tgt_age  (age[tgt]),
      .gate     (gate[v]),
      .note     (vnote[v]),
      .age      (age[v])
    );
  end
endmodule
